// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage of the RV32I direct-mapped-cache core.
// Formats store lanes/byte enables, issues one valid/ready data-cache
// request at a time, stalls upstream while the cache is busy, aligns and
// extends load data, and holds the MEM/WB pipeline register.
// Optional build macro: MISALIGN_TRAP_EN (adds misalign_o and suppresses
// misaligned half/word accesses instead of issuing them).
//
// Handshake: a request is offered while cache_valid_o=1 and completes in the
// cycle cache_ready_i=1 (read data is taken from cache_rdata_i in that same
// cycle); once offered, the request fields stay constant until completion.
module mem_stage #(
  parameter int          XLEN    = 32,
  parameter logic [31:0] RST_PC4 = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] alu_mem_i,
  input  logic [XLEN-1:0] rs2_mem_i,
  input  logic [XLEN-1:0] pc4_mem_i,
  input  logic            MemRW_mem_i,
  input  logic [1:0]      WBSel_mem_i,
  input  logic            RegWEn_mem_i,
  input  logic [4:0]      rsW_mem_i,
  input  logic [31:0]     inst_mem_i,
  input  logic            Valid_cpu2cache_mem_i,
  input  logic            enable_i,
  input  logic            reset_i,
  output logic            cache_valid_o,
  output logic            cache_we_o,
  output logic [XLEN-1:0] cache_addr_o,
  output logic [XLEN-1:0] cache_wdata_o,
  output logic [3:0]      cache_be_o,
  input  logic            cache_ready_i,
  input  logic [XLEN-1:0] cache_rdata_i,
  output logic            stall_o,
  output logic [XLEN-1:0] alu_wb_o,
  output logic [XLEN-1:0] ld_wb_o,
  output logic [XLEN-1:0] pc4_wb_o,
  output logic [1:0]      WBSel_wb_o,
  output logic            RegWEn_wb_o,
  output logic [4:0]      rsW_wb_o,
  output logic [31:0]     inst_wb_o,
`ifdef MISALIGN_TRAP_EN
  output logic            misalign_o,
`endif
  output logic            state_dbg
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [2:0]  f3;
  logic        misalign;
  logic        mem_req;
  logic [3:0]  be_in;
  logic [31:0] wdata_in;

  // Request registers: hold the access stable while the cache is busy.
  logic [31:0] req_addr;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [2:0]  req_f3;

  logic        done;
  logic        cur_load;
  logic [1:0]  cur_off;
  logic [2:0]  cur_f3;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;
  logic        wb_load;
  logic        flush_pend;

  assign f3        = inst_mem_i[14:12];
  assign state_dbg = state;

`ifdef MISALIGN_TRAP_EN
  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  always_comb begin
    misalign = 1'b0;
    if (Valid_cpu2cache_mem_i) begin
      if (f3[1:0] == 2'b01)      misalign = alu_mem_i[0];
      else if (f3 == 3'b010)     misalign = |alu_mem_i[1:0];
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign mem_req = Valid_cpu2cache_mem_i & ~misalign;

  // Store lane replication and byte enables; loads always read the whole word.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = rs2_mem_i;
    if (MemRW_mem_i) begin
      case (f3)
        3'b000: begin
          be_in    = 4'b0001 << alu_mem_i[1:0];
          wdata_in = {4{rs2_mem_i[7:0]}};
        end
        3'b001: begin
          be_in    = alu_mem_i[1] ? 4'b1100 : 4'b0011;
          wdata_in = {2{rs2_mem_i[15:0]}};
        end
        default: begin
          be_in    = 4'b1111;
          wdata_in = rs2_mem_i;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Capture the access when the cache does not accept it immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_be    <= '0;
      req_wdata <= '0;
      req_f3    <= '0;
    end else if (state == IDLE && mem_req && !cache_ready_i) begin
      req_addr  <= alu_mem_i;
      req_we    <= MemRW_mem_i;
      req_be    <= be_in;
      req_wdata <= wdata_in;
      req_f3    <= f3;
    end
  end

  // Next state, cache port fields, stall and completion.
  always_comb begin
    state_nxt     = state;
    cache_valid_o = 1'b0;
    cache_we_o    = MemRW_mem_i;
    cache_addr_o  = {alu_mem_i[31:2], 2'b00};
    cache_be_o    = be_in;
    cache_wdata_o = wdata_in;
    stall_o       = 1'b0;
    done          = 1'b0;
    cur_load      = mem_req & ~MemRW_mem_i;
    cur_off       = alu_mem_i[1:0];
    cur_f3        = f3;
    case (state)
      IDLE: begin
        cache_valid_o = mem_req;
        if (mem_req) begin
          if (cache_ready_i) begin
            done = 1'b1;
          end else begin
            stall_o   = 1'b1;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        cache_valid_o = 1'b1;
        cache_we_o    = req_we;
        cache_addr_o  = {req_addr[31:2], 2'b00};
        cache_be_o    = req_be;
        cache_wdata_o = req_wdata;
        cur_load      = ~req_we;
        cur_off       = req_addr[1:0];
        cur_f3        = req_f3;
        if (cache_ready_i) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall_o = 1'b1;
        end
      end
    endcase
    if (rst_i) begin
      cache_valid_o = 1'b0;
      stall_o       = 1'b0;
    end
  end

  // Load alignment and sign/zero extension of the completion-cycle read word.
  always_comb begin
    case (cur_off)
      2'd0:    ld_byte = cache_rdata_i[7:0];
      2'd1:    ld_byte = cache_rdata_i[15:8];
      2'd2:    ld_byte = cache_rdata_i[23:16];
      default: ld_byte = cache_rdata_i[31:24];
    endcase
    ld_half = cur_off[1] ? cache_rdata_i[31:16] : cache_rdata_i[15:0];
    ld_fmt  = '0;
    if (cur_load) begin
      case (cur_f3)
        3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
        3'b100:  ld_fmt = {24'h0, ld_byte};
        3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
        3'b101:  ld_fmt = {16'h0, ld_half};
        default: ld_fmt = cache_rdata_i;
      endcase
    end
  end

  assign wb_load = enable_i & ~stall_o;

  // A flush that arrives while stalled is remembered until the access completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  flush_pend <= 1'b0;
    else if (reset_i && stall_o) flush_pend <= 1'b1;
    else if (done)              flush_pend <= 1'b0;
  end

  // MEM/WB pipeline register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      alu_wb_o    <= '0;
      ld_wb_o     <= '0;
      pc4_wb_o    <= RST_PC4;
      WBSel_wb_o  <= '0;
      RegWEn_wb_o <= 1'b0;
      rsW_wb_o    <= '0;
      inst_wb_o   <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_o  <= 1'b0;
`endif
    end else if (wb_load) begin
      if (reset_i || flush_pend) begin
        alu_wb_o    <= '0;
        ld_wb_o     <= '0;
        pc4_wb_o    <= RST_PC4;
        WBSel_wb_o  <= '0;
        RegWEn_wb_o <= 1'b0;
        rsW_wb_o    <= '0;
        inst_wb_o   <= '0;
`ifdef MISALIGN_TRAP_EN
        misalign_o  <= 1'b0;
`endif
      end else begin
        alu_wb_o    <= alu_mem_i;
        ld_wb_o     <= ld_fmt;
        pc4_wb_o    <= pc4_mem_i;
        WBSel_wb_o  <= WBSel_mem_i;
        RegWEn_wb_o <= RegWEn_mem_i & ~misalign;
        rsW_wb_o    <= rsW_mem_i;
        inst_wb_o   <= inst_mem_i;
`ifdef MISALIGN_TRAP_EN
        misalign_o  <= misalign;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage with a transaction-level model
// of the cache port and the MEM/WB register, checked every clock.
module tb_mem_stage;
  localparam int W = 136;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] alu_mem_i, rs2_mem_i, pc4_mem_i, inst_mem_i;
  logic        MemRW_mem_i, RegWEn_mem_i, Valid_cpu2cache_mem_i;
  logic [1:0]  WBSel_mem_i;
  logic [4:0]  rsW_mem_i;
  logic        enable_i, reset_i;
  logic        cache_valid_o, cache_we_o;
  logic [31:0] cache_addr_o, cache_wdata_o;
  logic [3:0]  cache_be_o;
  logic        cache_ready_i;
  logic [31:0] cache_rdata_i;
  logic        stall_o;
  logic [31:0] alu_wb_o, ld_wb_o, pc4_wb_o, inst_wb_o;
  logic [1:0]  WBSel_wb_o;
  logic        RegWEn_wb_o;
  logic [4:0]  rsW_wb_o;
  logic        state_dbg;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .alu_mem_i(alu_mem_i), .rs2_mem_i(rs2_mem_i), .pc4_mem_i(pc4_mem_i),
    .MemRW_mem_i(MemRW_mem_i), .WBSel_mem_i(WBSel_mem_i),
    .RegWEn_mem_i(RegWEn_mem_i), .rsW_mem_i(rsW_mem_i),
    .inst_mem_i(inst_mem_i), .Valid_cpu2cache_mem_i(Valid_cpu2cache_mem_i),
    .enable_i(enable_i), .reset_i(reset_i),
    .cache_valid_o(cache_valid_o), .cache_we_o(cache_we_o),
    .cache_addr_o(cache_addr_o), .cache_wdata_o(cache_wdata_o),
    .cache_be_o(cache_be_o), .cache_ready_i(cache_ready_i),
    .cache_rdata_i(cache_rdata_i), .stall_o(stall_o),
    .alu_wb_o(alu_wb_o), .ld_wb_o(ld_wb_o), .pc4_wb_o(pc4_wb_o),
    .WBSel_wb_o(WBSel_wb_o), .RegWEn_wb_o(RegWEn_wb_o),
    .rsW_wb_o(rsW_wb_o), .inst_wb_o(inst_wb_o),
`ifdef MISALIGN_TRAP_EN
    .misalign_o(misalign_o),
`endif
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_wb;
  logic         exp_mem = 1'b0;
  logic [3:0]   exp_be  = 4'hF;
  logic [31:0]  exp_wdata = 32'h0;
  logic         flush_m = 1'b0;
  logic         stall_m, done_m;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [31:0] alu, input logic [31:0] ld,
                                        input logic [31:0] pc4, input logic [1:0] wbsel,
                                        input logic regwen, input logic [4:0] rsw,
                                        input logic [31:0] inst);
    return {alu, ld, pc4, wbsel, regwen, rsw, inst};
  endfunction

  function automatic logic [W-1:0] reset_vec();
    return pack(32'h0, 32'h0, 32'h0, 2'b00, 1'b0, 5'd0, 32'h0);
  endfunction

  // Loaded value from a read word: pick byte/half by address offset, then extend.
  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] st_be(input logic [2:0] f3, input logic [1:0] off);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2'd2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] st_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (f3 == 3'd0) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f3 == 3'd1) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // Model of the MEM/WB register: decide, at each edge, what it must hold next.
  always @(posedge clk) begin
    if (!rst_i) begin
      stall_m = exp_mem & ~cache_ready_i;
      done_m  = exp_mem & cache_ready_i;
      if (enable_i && !stall_m) begin
        if (reset_i || flush_m)
          exp_q.push_back(reset_vec());
        else
          exp_q.push_back(pack(alu_mem_i,
                               (Valid_cpu2cache_mem_i && !MemRW_mem_i) ?
                                 ld_model(inst_mem_i[14:12], alu_mem_i[1:0], cache_rdata_i) : 32'h0,
                               pc4_mem_i, WBSel_mem_i, RegWEn_mem_i, rsW_mem_i, inst_mem_i));
      end
      if (reset_i && stall_m) flush_m = 1'b1;
      else if (done_m)        flush_m = 1'b0;
    end
  end

  // Compare process: cache port, stall and WB register on every cycle.
  always @(negedge clk) begin
    if (rst_i) begin
      m_wb = reset_vec();
      exp_q.delete();
      flush_m = 1'b0;
      check("rst_cache_valid", W'(cache_valid_o), W'(1'b0));
      check("rst_stall", W'(stall_o), W'(1'b0));
      check("rst_wb", pack(alu_wb_o, ld_wb_o, pc4_wb_o, WBSel_wb_o, RegWEn_wb_o, rsW_wb_o, inst_wb_o), m_wb);
    end else begin
      check("cache_valid", W'(cache_valid_o), W'(exp_mem));
      if (exp_mem) begin
        check("cache_we", W'(cache_we_o), W'(MemRW_mem_i));
        check("cache_addr", W'(cache_addr_o), W'({alu_mem_i[31:2], 2'b00}));
        check("cache_be", W'(cache_be_o), W'(exp_be));
        if (MemRW_mem_i) check("cache_wdata", W'(cache_wdata_o), W'(exp_wdata));
      end
      check("stall", W'(stall_o), W'(exp_mem & ~cache_ready_i));
      while (exp_q.size() > 0) m_wb = exp_q.pop_front();
      check("wb_reg", pack(alu_wb_o, ld_wb_o, pc4_wb_o, WBSel_wb_o, RegWEn_wb_o, rsW_wb_o, inst_wb_o), m_wb);
    end
  end

  // ---------------- driver ----------------
  // One instruction: present it, hold ready low for 'waits' cycles (pulsing
  // reset_i in wait cycle 'flush_k'), then complete. Returns at #1 after the
  // completion edge with the stall-cycle count.
  task automatic run_op(input logic [31:0] inst, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [31:0] pc4,
                        input logic valid, input int waits,
                        input logic [31:0] rdata, input int flush_k,
                        output int stalls);
    logic we;
    we = (inst[6:0] == 7'b0100011);
    @(posedge clk); #1;
    inst_mem_i            = inst;
    alu_mem_i             = addr;
    rs2_mem_i             = rs2;
    pc4_mem_i             = pc4;
    MemRW_mem_i           = we;
    RegWEn_mem_i          = ~we;
    WBSel_mem_i           = valid ? 2'b00 : 2'b01;
    rsW_mem_i             = inst[11:7];
    Valid_cpu2cache_mem_i = valid;
    exp_mem               = valid;
    exp_be                = we ? st_be(inst[14:12], addr[1:0]) : 4'hF;
    exp_wdata             = st_wdata(inst[14:12], rs2);
    stalls = 0;
    for (int k = 0; k < waits; k++) begin
      cache_ready_i = 1'b0;
      cache_rdata_i = 32'h0;
      reset_i       = (k == flush_k);
      #1;
      if (stall_o) stalls++;
      @(posedge clk); #1;
    end
    reset_i       = 1'b0;
    cache_ready_i = valid;
    cache_rdata_i = rdata;
    @(posedge clk); #1;
    Valid_cpu2cache_mem_i = 1'b0;
    MemRW_mem_i           = 1'b0;
    cache_ready_i         = 1'b0;
    exp_mem               = 1'b0;
  endtask

  int st;

  initial begin
    rst_i = 1'b1;
    alu_mem_i = '0; rs2_mem_i = '0; pc4_mem_i = '0; inst_mem_i = '0;
    MemRW_mem_i = 1'b0; RegWEn_mem_i = 1'b0; WBSel_mem_i = '0; rsW_mem_i = '0;
    Valid_cpu2cache_mem_i = 1'b0; enable_i = 1'b1; reset_i = 1'b0;
    cache_ready_i = 1'b0; cache_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;

    // SW, zero-wait
    run_op(32'h00002023, 32'h00000100, 32'hDEADBEEF, 32'h00000104, 1'b1, 0, 32'h0, -1, st);
    check("sw_inst_wb", W'(inst_wb_o), W'(32'h00002023));
    check("sw_no_stall", W'(st), W'(0));

    // SB to top lane: be=1000, byte replicated
    @(posedge clk); #1;
    inst_mem_i = 32'h00000023; alu_mem_i = 32'h00000103; rs2_mem_i = 32'h000000A5;
    MemRW_mem_i = 1'b1; Valid_cpu2cache_mem_i = 1'b1; cache_ready_i = 1'b1;
    exp_mem = 1'b1; exp_be = st_be(3'd0, 2'd3); exp_wdata = st_wdata(3'd0, 32'hA5);
    RegWEn_mem_i = 1'b0; rsW_mem_i = 5'd0; pc4_mem_i = 32'h108;
    #1;
    check("sb_be_lit", W'(cache_be_o), W'(4'b1000));
    check("sb_wdata_lit", W'(cache_wdata_o), W'(32'hA5A5A5A5));
    @(posedge clk); #1;
    Valid_cpu2cache_mem_i = 1'b0; MemRW_mem_i = 1'b0; cache_ready_i = 1'b0; exp_mem = 1'b0;

    // LB / LBU with 3 wait cycles
    run_op(32'h00000283, 32'h00000202, 32'h0, 32'h0000010C, 1'b1, 3, 32'h12F03456, -1, st);
    check("lb_ld_lit", W'(ld_wb_o), W'(32'hFFFFFFF0));
    check("lb_stall_cycles", W'(st), W'(3));
    run_op(32'h00004283, 32'h00000202, 32'h0, 32'h00000110, 1'b1, 3, 32'h12F03456, -1, st);
    check("lbu_ld_lit", W'(ld_wb_o), W'(32'h000000F0));

    // LH / LHU upper half
    run_op(32'h00001283, 32'h00000102, 32'h0, 32'h00000114, 1'b1, 1, 32'h80011234, -1, st);
    check("lh_ld_lit", W'(ld_wb_o), W'(32'hFFFF8001));
    run_op(32'h00005283, 32'h00000102, 32'h0, 32'h00000118, 1'b1, 0, 32'h80011234, -1, st);
    check("lhu_ld_lit", W'(ld_wb_o), W'(32'h00008001));

    // LW and a low-half LH
    run_op(32'h00002283, 32'h00000300, 32'h0, 32'h0000011C, 1'b1, 2, 32'hCAFEF00D, -1, st);
    check("lw_ld_lit", W'(ld_wb_o), W'(32'hCAFEF00D));
    run_op(32'h00001283, 32'h00000300, 32'h0, 32'h00000120, 1'b1, 0, 32'hCAFE7F0D, -1, st);
    check("lh_lo_ld_lit", W'(ld_wb_o), W'(32'h00007F0D));

    // SH to upper half, then non-memory pass-through
    run_op(32'h00001023, 32'h00000402, 32'h0000BEEF, 32'h00000124, 1'b1, 2, 32'h0, -1, st);
    run_op(32'h000002B3, 32'h00001234, 32'h0, 32'h00000128, 1'b0, 0, 32'h0, -1, st);
    check("alu_pass_lit", W'(alu_wb_o), W'(32'h00001234));
    check("alu_ld_zero", W'(ld_wb_o), W'(32'h0));

    // Flush pulsed during WAIT: access still completes, WB zeroed
    run_op(32'h00002283, 32'h00000500, 32'h0, 32'h0000012C, 1'b1, 3, 32'h55555555, 1, st);
    check("flush_stall_cycles", W'(st), W'(3));
    check("flush_inst_wb", W'(inst_wb_o), W'(32'h0));
    check("flush_ld_wb", W'(ld_wb_o), W'(32'h0));

    // A plain instruction after the flush loads normally again
    run_op(32'h000002B3, 32'h00000777, 32'h0, 32'h00000130, 1'b0, 0, 32'h0, -1, st);
    check("post_flush_alu", W'(alu_wb_o), W'(32'h00000777));

    // Asynchronous reset in the middle of a wait
    @(posedge clk); #1;
    inst_mem_i = 32'h00002283; alu_mem_i = 32'h00000600; pc4_mem_i = 32'h00000134;
    MemRW_mem_i = 1'b0; RegWEn_mem_i = 1'b1; rsW_mem_i = 5'd5;
    Valid_cpu2cache_mem_i = 1'b1; cache_ready_i = 1'b0; exp_mem = 1'b1; exp_be = 4'hF;
    @(posedge clk); #1;
    check("wait_state_dbg", W'(state_dbg), W'(1'b1));
    #1 rst_i = 1'b1;
    #1;
    check("rst_async_valid", W'(cache_valid_o), W'(1'b0));
    check("rst_async_stall", W'(stall_o), W'(1'b0));
    check("rst_async_alu", W'(alu_wb_o), W'(32'h0));
    check("rst_async_pc4", W'(pc4_wb_o), W'(32'h0));
    check("rst_async_state", W'(state_dbg), W'(1'b0));
    Valid_cpu2cache_mem_i = 1'b0; exp_mem = 1'b0;
    @(posedge clk); #1 rst_i = 1'b0;

    run_op(32'h00002023, 32'h00000700, 32'h01234567, 32'h00000138, 1'b1, 1, 32'h0, -1, st);
    check("post_rst_inst", W'(inst_wb_o), W'(32'h00002023));
    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage directly downstream of EX in the RV32I direct-mapped-cache core.
- Consumes the EX/MEM register outputs and drives a single-request valid/ready data-cache port.
- Formats store data and byte enables, aligns and extends load data, stalls the pipeline while the cache is busy, and holds the MEM/WB pipeline register.

Parameters:
- XLEN, 32, datapath width (only 32 supported)
- RST_PC4, 32'h0, reset value of pc4_wb_o

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- alu_mem_i  in  32  effective address / ALU result from EX
- rs2_mem_i  in  32  store data from EX
- pc4_mem_i  in  32  PC+4 from EX
- MemRW_mem_i  in  1  1=store, 0=load
- WBSel_mem_i  in  2  writeback select, passed through
- RegWEn_mem_i  in  1  register write enable
- rsW_mem_i  in  5  destination register
- inst_mem_i  in  32  instruction; funct3 = inst_mem_i[14:12]
- Valid_cpu2cache_mem_i  in  1  instruction accesses memory
- enable_i  in  1  MEM/WB register load enable from hazard unit
- reset_i  in  1  synchronous flush of MEM/WB register
- cache_valid_o  out  1  request valid
- cache_we_o  out  1  request is store
- cache_addr_o  out  32  word address {addr[31:2],2'b00}
- cache_wdata_o  out  32  lane-replicated store data
- cache_be_o  out  4  byte enables
- cache_ready_i  in  1  cache accepts/completes request this cycle
- cache_rdata_i  in  32  read word, valid when cache_ready_i=1
- stall_o  out  1  freeze PC/IF/ID/EX
- alu_wb_o  out  32  registered ALU result
- ld_wb_o  out  32  registered formatted load data
- pc4_wb_o  out  32  registered PC+4
- WBSel_wb_o  out  2  registered WBSel
- RegWEn_wb_o  out  1  registered RegWEn
- rsW_wb_o  out  5  registered rsW
- inst_wb_o  out  32  registered instruction

Behaviour:
- Reset (rst_i=1, asynchronous): FSM=IDLE; all *_wb_o=0 (pc4_wb_o=RST_PC4); flush_pend=0. cache_valid_o and stall_o are forced 0 while rst_i=1.
- Store formatting by funct3:
  - SB: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{rs2[15:0]}}
  - SW: be=4'b1111, wdata=rs2
  - Loads drive be=4'b1111.
- FSM states and transitions:
  - IDLE: cache_valid_o=Valid_cpu2cache_mem_i, fields combinational from inputs. If valid & ready, zero-wait completion, stay IDLE. If valid & !ready, capture addr/we/be/wdata/funct3 into request regs and go to WAIT.
  - WAIT: cache_valid_o=1, fields from request regs (stable until accepted). On ready, complete and go to IDLE.
- stall_o = (IDLE & valid & !ready) | (WAIT & !ready). On the completion cycle stall_o=0, so the upstream stages advance in that cycle.
- Load formatting uses the completion-cycle cache_rdata_i and addr[1:0] (the captured copy in WAIT):
  - LB/LBU: byte select, sign/zero extend
  - LH/LHU: half select, sign/zero extend
  - LW: whole word
  - Any other funct3: word passed unchanged.
  - Non-load instructions: ld_wb_o loads 0.
- MEM/WB register update:
  - Loads only when enable_i & !stall_o.
  - If reset_i or flush_pend: all *_wb_o=0 (pc4 = RST_PC4).
  - Otherwise: load from the *_mem_i inputs and formatted load data.
- Flush during WAIT: reset_i=1 sets flush_pend. The outstanding cache access is never aborted. On completion the WB register is zeroed, then flush_pend is cleared.
- Latency: MEM/WB register updates on the completion edge, i.e. 1 cycle after a zero-wait access and N+1 cycles after issue for N wait cycles.
- Non-memory instructions pass through with 1-cycle latency and no stall.
- Misaligned address with the feature off: issued as is. The low address bits select lanes; LW/SW ignore addr[1:0].

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - A misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0) with valid=1 issues no cache request and raises no stall.
  - The WB register loads with RegWEn_wb_o=0, and misalign_o=1 for that instruction.
- When undefined: no port, no checking, behaviour as above.

Test Plan:
- SW addr=0x100, rs2=0xDEADBEEF, ready=1 same cycle -> be=4'hF, wdata=0xDEADBEEF, stall_o never 1, next edge inst_wb_o updated.
- SB addr=0x103, rs2=0x000000A5 -> be=4'b1000, wdata=0xA5A5A5A5.
- LB addr=0x202, rdata=0x12F03456, ready delayed 3 cycles -> stall_o=1 for 3 cycles, cache fields stable, ld_wb_o=0xFFFFFFF0. Same access with LBU -> 0x000000F0.
- LH addr=0x102, rdata=0x8001xxxx -> ld_wb_o=0xFFFF8001. LHU -> 0x00008001.
- reset_i pulsed in WAIT, ready 2 cycles later -> request still held until ready, then all *_wb_o=0.
- rst_i asserted mid-WAIT -> cache_valid_o=0, stall_o=0 immediately; FSM=IDLE and all *_wb_o=0 (pc4_wb_o=RST_PC4).
